pipe_skid_reg: RTL and testbench
================================

Name: pipe_skid_reg

Overview:
Parametrised pipeline-stage register, the generalised successor of the fixed-field stage registers between core pipeline stages.
- Carries an opaque DATA_W payload plus a CTRL_W control vector that is zeroed to form a bubble.
- Adds a valid/ready handshake with a 2-entry skid buffer, so throughput is 1/cycle and up_ready_o never depends on dn_ready_i.
- Keeps the flow-control (fc) flush and hold inputs.

Parameters:
DATA_W, 32, payload width (operands, addresses, write data); never cleared except by reset.
CTRL_W, 8, control width (reg_we, mem_rw, mtype, ...); forced to 0 whenever the stage presents no valid entry.
CNT_W, 16, width of the optional stall counter.

Ports:
clk  in  1  clock; all state on the rising edge.
rst  in  1  asynchronous reset, active-high.
up_valid_i  in  1  upstream entry valid.
up_ready_o  out  1  stage can accept.
up_data_i  in  DATA_W  upstream payload.
up_ctrl_i  in  CTRL_W  upstream control.
dn_valid_o  out  1  downstream entry valid.
dn_ready_i  in  1  downstream accepts.
dn_data_o  out  DATA_W  payload of the head entry.
dn_ctrl_o  out  CTRL_W  control of the head entry; 0 when dn_valid_o=0.
fc_flush_i  in  1  flush from flow control.
fc_hold_i  in  1  hold (break) from flow control.
occupancy_o  out  2  entries held: 0, 1 or 2.
stall_cnt_o  out  CNT_W  stall counter (see Optional Feature).

Behaviour:
- Interface decision: one clock, clk; reset is asynchronous and active-high, named rst.
- Storage:
  - Main entry M (data, ctrl, valid).
  - Skid entry S (data, ctrl, valid).
  - State EMPTY (0), ONE (M valid) or TWO (M and S valid).
  - occupancy_o equals the state encoding.
- Reset:
  - State EMPTY; all M and S fields 0.
  - dn_valid_o=0, dn_data_o=0, dn_ctrl_o=0, occupancy_o=0, stall_cnt_o=0.
  - up_ready_o=1 when fc_hold_i=0.
  - Reset asserted mid-operation discards every entry immediately, without waiting for a clock edge.
- Handshake:
  - up_ready_o = (state!=TWO) & !fc_hold_i & !fc_flush_i.
  - dn_valid_o = M.valid & !fc_hold_i & !fc_flush_i.
  - in = up_valid_i & up_ready_o; out = dn_valid_o & dn_ready_i.
- Transitions when no flush:
  - EMPTY: on in, go to ONE with M <= input.
  - ONE: in & out -> ONE, M <= input. in & !out -> TWO, S <= input. !in & out -> EMPTY. Neither -> ONE, unchanged.
  - TWO: out -> ONE, M <= S, S cleared. Otherwise unchanged. in is impossible because up_ready_o=0.
- Latency and ordering: an accepted entry reaches dn_valid_o on the next cycle. Entries are delivered strictly in acceptance order, with no loss and no duplication.
- Hold (fc_hold_i=1, fc_flush_i=0): no transfer on either side and all state frozen. Occupancy 2 survives any length of hold.
- Flush (fc_flush_i=1):
  - Flush has priority over hold.
  - Next state is EMPTY, with every M and S field zeroed.
  - Any input presented in the flush cycle is dropped.
  - No downstream transfer occurs in that cycle.
- dn_data_o is always M.data, so it holds the stale value after a drain. dn_ctrl_o = M.valid ? M.ctrl : 0.

Optional Feature:
Macro PIPE_SKID_PERF_EN.
- Defined: stall_cnt_o increments every cycle in which M.valid & !dn_ready_i & !fc_hold_i & !fc_flush_i holds.
  - Saturates at 2^CNT_W-1.
  - Cleared only by rst; unaffected by flush.
- Undefined: no counter logic is built and stall_cnt_o is tied to 0. The port list is identical in both builds.

Decomposition:
- Shared package pipe_pkg holds:
  - the state typedef pipe_occ_e (EMPTY=2'd0, ONE=2'd1, TWO=2'd2);
  - the CTRL_BUBBLE constant (all zeros).
- One sub-module, pipe_sat_cnt: a CNT_W saturating counter with inc and asynchronous active-high rst. It is instantiated only under PIPE_SKID_PERF_EN.

Test Plan:
1. Stream 0x1, 0x2, 0x3 back-to-back with dn_ready_i=1 -> each appears one cycle after acceptance; up_ready_o stays 1; occupancy_o stays 1.
2. dn_ready_i=0, push 0xA then 0xB, offer 0xC -> occupancy_o=2, up_ready_o=0, 0xC not accepted. Raise dn_ready_i -> 0xA, 0xB, 0xC delivered in order, no duplicates.
3. State TWO, fc_flush_i=1 together with up_valid_i=1 carrying 0xD -> next cycle occupancy_o=0, dn_valid_o=0, dn_ctrl_o=0; 0xD never appears.
4. State ONE holding 0x55 with ctrl 0x3F, dn_ready_i=1, fc_hold_i=1 for 3 cycles -> dn_valid_o=0, up_ready_o=0, contents unchanged. Release -> 0x55/0x3F delivered. Hold and flush asserted together -> flush wins.
5. Assert rst asynchronously between edges while in state TWO -> all outputs go to reset values immediately; after release up_ready_o=1 and occupancy_o=0.
6. PIPE_SKID_PERF_EN with CNT_W=4, valid entry and dn_ready_i=0 for 5 cycles -> stall_cnt_o=5. Continue for 20 cycles -> saturates at 15. Then flush -> still 15.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline skid-buffer stage.
//   pipe_occ_e  : stage occupancy state; its encoding is the entry count.
//   CTRL_BUBBLE : control value presented when the stage has no valid entry.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_occ_e;

  // Wide enough for any practical CTRL_W; users truncate with CTRL_W'(...).
  localparam logic [63:0] CTRL_BUBBLE = 64'd0;

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter used for stage stall statistics.
// Ports:
//   clk  : clock
//   rst  : asynchronous reset, active-high (clears count)
//   inc  : increment request for this cycle
//   cnt  : current count, sticks at all-ones
module pipe_sat_cnt #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  // Count up until all ones, then hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline-stage register with a valid/ready handshake and a 2-entry skid
// buffer (main entry M, skid entry S). Full throughput; up_ready_o never
// depends on dn_ready_i. Flow-control flush empties the stage, hold freezes it.
// Optional macro PIPE_SKID_PERF_EN builds a saturating stall counter;
// otherwise stall_cnt_o is tied to 0.
// Ports:
//   clk, rst                : clock, asynchronous active-high reset
//   up_valid_i/up_ready_o   : upstream handshake
//   up_data_i/up_ctrl_i     : upstream payload and control
//   dn_valid_o/dn_ready_i   : downstream handshake
//   dn_data_o/dn_ctrl_o     : head entry payload; ctrl is 0 when M is empty
//   fc_flush_i/fc_hold_i    : flow-control flush (wins) and hold
//   occupancy_o             : entries held (0..2)
//   stall_cnt_o             : stall counter
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              up_valid_i,
  output logic              up_ready_o,
  input  logic [DATA_W-1:0] up_data_i,
  input  logic [CTRL_W-1:0] up_ctrl_i,
  output logic              dn_valid_o,
  input  logic              dn_ready_i,
  output logic [DATA_W-1:0] dn_data_o,
  output logic [CTRL_W-1:0] dn_ctrl_o,
  input  logic              fc_flush_i,
  input  logic              fc_hold_i,
  output logic [1:0]        occupancy_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  pipe_occ_e         state, state_n;
  logic [DATA_W-1:0] m_data, m_data_n, s_data, s_data_n;
  logic [CTRL_W-1:0] m_ctrl, m_ctrl_n, s_ctrl, s_ctrl_n;
  logic              m_valid;
  logic              xfer_in, xfer_out;

  // M is valid in ONE and TWO; S is valid only in TWO.
  assign m_valid    = (state != EMPTY);
  assign up_ready_o = (state != TWO) && !fc_hold_i && !fc_flush_i;
  assign dn_valid_o = m_valid && !fc_hold_i && !fc_flush_i;
  assign xfer_in    = up_valid_i && up_ready_o;
  assign xfer_out   = dn_valid_o && dn_ready_i;

  assign dn_data_o   = m_data;
  assign dn_ctrl_o   = m_valid ? m_ctrl : CTRL_W'(CTRL_BUBBLE);
  assign occupancy_o = 2'(state);

  // State and entry registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= EMPTY;
      m_data <= '0;
      m_ctrl <= '0;
      s_data <= '0;
      s_ctrl <= '0;
    end else begin
      state  <= state_n;
      m_data <= m_data_n;
      m_ctrl <= m_ctrl_n;
      s_data <= s_data_n;
      s_ctrl <= s_ctrl_n;
    end
  end

  // Next-state and entry update; hold needs no branch since it blocks both transfers.
  always_comb begin
    state_n  = state;
    m_data_n = m_data;
    m_ctrl_n = m_ctrl;
    s_data_n = s_data;
    s_ctrl_n = s_ctrl;
    if (fc_flush_i) begin
      state_n  = EMPTY;
      m_data_n = '0;
      m_ctrl_n = '0;
      s_data_n = '0;
      s_ctrl_n = '0;
    end else begin
      case (state)
        EMPTY: begin
          if (xfer_in) begin
            state_n  = ONE;
            m_data_n = up_data_i;
            m_ctrl_n = up_ctrl_i;
          end
        end
        ONE: begin
          if (xfer_in && xfer_out) begin
            m_data_n = up_data_i;
            m_ctrl_n = up_ctrl_i;
          end else if (xfer_in) begin
            state_n  = TWO;
            s_data_n = up_data_i;
            s_ctrl_n = up_ctrl_i;
          end else if (xfer_out) begin
            // M data is left stale on purpose; only validity drops.
            state_n = EMPTY;
          end
        end
        TWO: begin
          if (xfer_out) begin
            state_n  = ONE;
            m_data_n = s_data;
            m_ctrl_n = s_ctrl;
            s_data_n = '0;
            s_ctrl_n = '0;
          end
        end
        default: begin
          state_n = EMPTY;
        end
      endcase
    end
  end

`ifdef PIPE_SKID_PERF_EN
  logic stall_inc;

  // A stall is a presented entry that downstream refuses.
  assign stall_inc = m_valid && !dn_ready_i && !fc_hold_i && !fc_flush_i;

  pipe_sat_cnt #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall_inc),
    .cnt (stall_cnt_o)
  );
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
module tb_pipe_skid_reg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CTRL_W = 8;
  localparam int unsigned CNT_W  = 4;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [CTRL_W-1:0] c;
  } entry_t;

  logic              clk, rst;
  logic              up_valid, up_ready, dn_valid, dn_ready, fc_flush, fc_hold;
  logic [DATA_W-1:0] up_data, dn_data;
  logic [CTRL_W-1:0] up_ctrl, dn_ctrl;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt;

  pipe_skid_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .up_valid_i  (up_valid),
    .up_ready_o  (up_ready),
    .up_data_i   (up_data),
    .up_ctrl_i   (up_ctrl),
    .dn_valid_o  (dn_valid),
    .dn_ready_i  (dn_ready),
    .dn_data_o   (dn_data),
    .dn_ctrl_o   (dn_ctrl),
    .fc_flush_i  (fc_flush),
    .fc_hold_i   (fc_hold),
    .occupancy_o (occupancy),
    .stall_cnt_o (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: FIFO of accepted-but-undelivered entries, plus counters.
  entry_t sb[$];
  int     model_occ;
  int     model_stall;
  int     n_tests;
  int     n_fail;
  int     n_seen_d;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every downstream transfer must match the oldest accepted entry.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && dn_valid && dn_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 64'(dn_data), 64'hDEAD_0000);
        end else begin
          entry_t e;
          e = sb.pop_front();
          chk("out_data", 64'(dn_data), 64'(e.d));
          chk("out_ctrl", 64'(dn_ctrl), 64'(e.c));
          n_seen_d++;
        end
      end
    end
  end

  // One clock of stimulus; checks visible state before the edge commits it.
  task automatic cycle(input logic uv, input logic [DATA_W-1:0] ud,
                       input logic [CTRL_W-1:0] uc, input logic dr,
                       input logic fl, input logic ho);
    logic exp_ur, exp_dv, acc, dlv;
    entry_t e;
    @(posedge clk);
    #1;
    up_valid = uv; up_data = ud; up_ctrl = uc;
    dn_ready = dr; fc_flush = fl; fc_hold = ho;
    @(negedge clk);
    exp_ur = (model_occ < 2) && !ho && !fl;
    exp_dv = (model_occ > 0) && !ho && !fl;
    chk("up_ready", 64'(up_ready), 64'(exp_ur));
    chk("dn_valid", 64'(dn_valid), 64'(exp_dv));
    chk("occupancy", 64'(occupancy), 64'(model_occ));
    chk("stall_cnt", 64'(stall_cnt), 64'(model_stall));
    if (model_occ == 0) begin
      chk("bubble_ctrl", 64'(dn_ctrl), 64'd0);
    end else if (!(exp_dv && dr)) begin
      // No transfer this cycle, so the head is stable for a peek.
      chk("head_data", 64'(dn_data), 64'(sb[0].d));
      chk("head_ctrl", 64'(dn_ctrl), 64'(sb[0].c));
    end
    acc = uv && exp_ur;
    dlv = exp_dv && dr;
`ifdef PIPE_SKID_PERF_EN
    if (model_occ > 0 && !dr && !ho && !fl && model_stall < CNT_MAX) model_stall++;
`endif
    if (fl) begin
      sb.delete();
      model_occ = 0;
    end else begin
      if (acc) begin
        e.d = ud; e.c = uc;
        sb.push_back(e);
      end
      model_occ = model_occ + int'(acc) - int'(dlv);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_dn_valid"}, 64'(dn_valid), 64'd0);
    chk({tag, "_dn_data"}, 64'(dn_data), 64'd0);
    chk({tag, "_dn_ctrl"}, 64'(dn_ctrl), 64'd0);
    chk({tag, "_occupancy"}, 64'(occupancy), 64'd0);
    chk({tag, "_stall"}, 64'(stall_cnt), 64'd0);
    chk({tag, "_up_ready"}, 64'(up_ready), 64'd1);
  endtask

  initial begin
    n_tests = 0; n_fail = 0; n_seen_d = 0;
    model_occ = 0; model_stall = 0;
    rst = 1'b1;
    up_valid = 0; up_data = '0; up_ctrl = '0;
    dn_ready = 0; fc_flush = 0; fc_hold = 0;
    #12;
    chk_reset_outputs("reset");
    #10 rst = 1'b0;

    // Back-to-back stream with downstream always ready.
    cycle(1, 32'h1, 8'h11, 1, 0, 0);
    cycle(1, 32'h2, 8'h12, 1, 0, 0);
    cycle(1, 32'h3, 8'h13, 1, 0, 0);
    cycle(0, 32'h0, 8'h00, 1, 0, 0);

    // Fill the skid, offer a third entry while full, then drain.
    cycle(1, 32'hA, 8'h21, 0, 0, 0);
    cycle(1, 32'hB, 8'h22, 0, 0, 0);
    cycle(1, 32'hC, 8'h23, 0, 0, 0);
    cycle(1, 32'hC, 8'h23, 1, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 32'h0, 8'h00, 1, 0, 0);

    // Flush in state TWO drops both entries and the concurrent input.
    cycle(1, 32'h41, 8'h31, 0, 0, 0);
    cycle(1, 32'h42, 8'h32, 0, 0, 0);
    cycle(1, 32'hD, 8'h33, 0, 1, 0);
    cycle(0, 32'h0, 8'h00, 1, 0, 0);
    chk("flush_data_zero", 64'(dn_data), 64'd0);

    // Hold freezes a ONE-state entry, then release delivers it; hold+flush flushes.
    cycle(1, 32'h55, 8'h3F, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(1, 32'h66, 8'h01, 1, 0, 1);
    cycle(0, 32'h0, 8'h00, 1, 0, 0);
    cycle(1, 32'h77, 8'h02, 0, 0, 0);
    cycle(1, 32'h78, 8'h03, 0, 1, 1);
    cycle(0, 32'h0, 8'h00, 1, 0, 0);

    // Occupancy two survives a long hold.
    cycle(1, 32'h81, 8'h04, 0, 0, 0);
    cycle(1, 32'h82, 8'h05, 0, 0, 0);
    for (int i = 0; i < 6; i++) cycle(0, 32'h0, 8'h00, 1, 0, 1);
    for (int i = 0; i < 3; i++) cycle(0, 32'h0, 8'h00, 1, 0, 0);

    // Stall counting and saturation, then flush leaves the count alone.
    cycle(1, 32'h91, 8'h06, 0, 0, 0);
    for (int i = 0; i < 25; i++) cycle(0, 32'h0, 8'h00, 0, 0, 0);
    cycle(0, 32'h0, 8'h00, 0, 1, 0);
    cycle(0, 32'h0, 8'h00, 0, 0, 0);

    // Asynchronous reset between edges while in state TWO.
    cycle(1, 32'hA1, 8'h07, 0, 0, 0);
    cycle(1, 32'hA2, 8'h08, 0, 0, 0);
    cycle(0, 32'h0, 8'h00, 0, 0, 0);
    up_valid = 0;
    #3 rst = 1'b1;
    #1;
    chk_reset_outputs("async_rst");
    sb.delete(); model_occ = 0; model_stall = 0;
    #4 rst = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), $urandom(), 8'($urandom()),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 31) == 0),
            1'($urandom_range(0, 7) == 0));
    end

    // Drain and confirm nothing is left undelivered.
    for (int i = 0; i < 4; i++) cycle(0, 32'h0, 8'h00, 1, 0, 0);
    chk("drained", 64'(sb.size()), 64'd0);
    chk("some_delivered", 64'(n_seen_d > 100), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
